// File: rtl/hazard_pkg.sv
// Shared definitions for the load-use / branch hazard controller: opcodes,
// controller states and source-register usage decode.
package hazard_pkg;

    localparam logic [6:0] OP_NOP    = 7'b0000000;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IARITH = 7'b0010011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_e;

    function automatic logic uses_rs1(input logic [6:0] opcode);
        logic r;
        case (opcode)
            OP_LOAD, OP_IARITH, OP_RTYPE, OP_STORE, OP_BRANCH: r = 1'b1;
            default:                                           r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        logic r;
        case (opcode)
            OP_RTYPE, OP_STORE, OP_BRANCH: r = 1'b1;
            default:                       r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rs_use_decode.sv
// Combinational decode of which source registers an IF/ID opcode reads.
module rs_use_decode
    import hazard_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       use1,
    output logic       use2
);

    always_comb begin
        use1 = uses_rs1(opcode);
        use2 = uses_rs2(opcode);
    end

endmodule

// File: rtl/hazard_unit.sv
// Load-use stall and taken-branch flush controller for the IF/ID and ID/EX
// pipeline registers, with saturating stall/flush event counters.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       if_id_opcode,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic [4:0]       id_ex_rd,
    input  logic             id_ex_memread,
    input  logic             ex_branch_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             control_sel,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [2:0] STALL_INIT = 3'(LOAD_STALL_CYCLES - 1);
    localparam bit         MULTI      = (LOAD_STALL_CYCLES > 1);

    state_e             state_q, state_d;
    logic [2:0]         rem_q, rem_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic               use1, use2;
    logic               hz;

    rs_use_decode u_rs_use_decode (
        .opcode (if_id_opcode),
        .use1   (use1),
        .use2   (use2)
    );

    always_comb begin
        hz = id_ex_memread && (id_ex_rd != 5'd0) &&
             ((use1 && (if_id_rs1 == id_ex_rd)) ||
              (use2 && (if_id_rs2 == id_ex_rd)));
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Branch flush takes priority over both a fresh hazard and an ongoing stall.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        control_sel = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;

        if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            control_sel = 1'b1;
            flush_cnt_d = sat_inc(flush_cnt_q);
            state_d     = RUN;
            rem_d       = 3'd0;
        end else if (state_q == STALL) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            control_sel = 1'b1;
            stall_cnt_d = sat_inc(stall_cnt_q);
            if (rem_q <= 3'd1) begin
                state_d = RUN;
                rem_d   = 3'd0;
            end else begin
                rem_d   = rem_q - 3'd1;
            end
        end else if (hz) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            control_sel = 1'b1;
            stall_cnt_d = sat_inc(stall_cnt_q);
            if (MULTI) begin
                state_d = STALL;
                rem_d   = STALL_INIT;
            end
        end

        // While reset is held the decoder is kept bubbling and nothing advances.
        if (!rst_n) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            control_sel = 1'b1;
            if_id_flush = 1'b0;
            id_ex_flush = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            rem_q       <= 3'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule
